cpu_bus_cycle_master: RTL and testbench

Synthesisable 8088-style bus-cycle initiator: the CPU-side end of the processor-status/ready protocol that the chipset's bus arbiter and ready logic decode. It takes simple request/response transactions from an internal core or a test sequencer, sequences T1-T2-T3-(TW)*-T4 bus cycles on `processor_status`/`cpu_address`/`cpu_data_bus`, and honours `processor_ready` wait states. It returns read data, or an error on a ready timeout.

---
 rtl/cpu_bus_cycle_master.sv | 186 ++++++++++++++++++
 tb/tb_cpu_bus_cycle_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_cycle_master.sv
// 8088-style bus-cycle initiator: sequences T1-T2-T3-(TW)*-T4 on the status/ready
// protocol and returns read data, or an error on a ready timeout or invalid type.
//
// state | meaning
// IDLE  | bus passive, accepting requests
// T1    | status and address driven
// T2    | write data driven for write types
// T3    | first ready sample (halt skips the sample)
// TW    | wait state, ready sampled each cycle against the timeout
// T4    | response pulse, bus passive, next request may be accepted
// ERR   | one-cycle error response for an invalid request type
module cpu_bus_cycle_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 11
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [19:0] req_address,
    input  logic [7:0]  req_wdata,
    input  logic        req_lock,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic [2:0]  processor_status,
    output logic        processor_lock_n,
    output logic [19:0] cpu_address,
    output logic [7:0]  cpu_data_bus,
    input  logic        processor_ready,
    input  logic [7:0]  data_bus_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_TW,
        S_T4,
        S_ERR
    } state_t;

    localparam logic [2:0] TYPE_INTA    = 3'b000;
    localparam logic [2:0] TYPE_IO_RD   = 3'b001;
    localparam logic [2:0] TYPE_IO_WR   = 3'b010;
    localparam logic [2:0] TYPE_HALT    = 3'b011;
    localparam logic [2:0] TYPE_CODE    = 3'b100;
    localparam logic [2:0] TYPE_MEM_RD  = 3'b101;
    localparam logic [2:0] TYPE_MEM_WR  = 3'b110;
    localparam logic [2:0] TYPE_INVALID = 3'b111;

    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    state_t                   state_q, state_d;
    logic [2:0]               type_q;
    logic [19:0]              addr_q;
    logic [7:0]               wdata_q;
    logic                     lock_q;
    logic [TIMEOUT_WIDTH-1:0] wait_q;
    logic                     err_q;
    logic [7:0]               rdata_q;

    logic accept;
    logic capture;
    logic timeout;
    logic wait_inc;
    logic type_is_read;
    logic type_is_write;

    assign type_is_read  = (type_q == TYPE_INTA) || (type_q == TYPE_IO_RD) ||
                           (type_q == TYPE_CODE) || (type_q == TYPE_MEM_RD);
    assign type_is_write = (type_q == TYPE_IO_WR) || (type_q == TYPE_MEM_WR);

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        wait_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = (req_type == TYPE_INVALID) ? S_ERR : S_T1;
                end
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                if (type_q == TYPE_HALT) begin
                    state_d = S_T4;
                end else if (processor_ready) begin
                    capture = 1'b1;
                    state_d = S_T4;
                end else begin
                    wait_inc = 1'b1;
                    state_d  = S_TW;
                end
            end
            S_TW: begin
                // ready in the last allowed wait state still completes normally
                if (processor_ready) begin
                    capture = 1'b1;
                    state_d = S_T4;
                end else if (wait_q == WAIT_LIMIT) begin
                    timeout = 1'b1;
                    state_d = S_T4;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_T4: begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
                rsp_error = err_q;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = (req_type == TYPE_INVALID) ? S_ERR : S_T1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_error = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            type_q  <= TYPE_INVALID;
            addr_q  <= '0;
            wdata_q <= '0;
            lock_q  <= 1'b0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && (req_type != TYPE_INVALID)) begin
                type_q  <= req_type;
                addr_q  <= req_address;
                wdata_q <= req_wdata;
                lock_q  <= req_lock;
                wait_q  <= '0;
                err_q   <= 1'b0;
            end
            if (wait_inc) begin
                wait_q <= wait_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (capture && type_is_read) begin
                rdata_q <= data_bus_in;
            end
        end
    end

    logic bus_active;
    logic data_phase;
    logic lock_phase;

    assign bus_active = (state_q == S_T1) || (state_q == S_T2) ||
                        (state_q == S_T3) || (state_q == S_TW);
    assign data_phase = (state_q == S_T2) || (state_q == S_T3) ||
                        (state_q == S_TW) || (state_q == S_T4);
    assign lock_phase = bus_active || (state_q == S_T4);

    assign processor_status = bus_active ? type_q : 3'b111;
    assign processor_lock_n = lock_phase ? ~lock_q : 1'b1;
    assign cpu_address      = addr_q;
    assign cpu_data_bus     = (data_phase && type_is_write) ? wdata_q : 8'h00;
    assign rsp_rdata        = rdata_q;

endmodule

// File: tb/tb_cpu_bus_cycle_master.sv
// Directed bench for cpu_bus_cycle_master: reads, writes with waits, timeout,
// back-to-back, invalid type, halt and reset during a wait state.
module tb_cpu_bus_cycle_master;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [19:0] req_address;
    logic [7:0]  req_wdata;
    logic        req_lock;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic [2:0]  processor_status;
    logic        processor_lock_n;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_data_bus;
    logic        processor_ready;
    logic [7:0]  data_bus_in;

    int n_compared   = 0;
    int n_mismatched = 0;

    cpu_bus_cycle_master #(
        .TIMEOUT_CYCLES(4),
        .TIMEOUT_WIDTH (11)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_type        (req_type),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .req_lock        (req_lock),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .processor_status(processor_status),
        .processor_lock_n(processor_lock_n),
        .cpu_address     (cpu_address),
        .cpu_data_bus    (cpu_data_bus),
        .processor_ready (processor_ready),
        .data_bus_in     (data_bus_in)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic drive_req(input logic [2:0] t, input logic [19:0] a,
                             input logic [7:0] w, input logic l);
        req_valid   = 1'b1;
        req_type    = t;
        req_address = a;
        req_wdata   = w;
        req_lock    = l;
    endtask

    initial begin
        reset_n         = 1'b0;
        req_valid       = 1'b0;
        req_type        = 3'b000;
        req_address     = '0;
        req_wdata       = '0;
        req_lock        = 1'b0;
        processor_ready = 1'b1;
        data_bus_in     = 8'h00;
        repeat (3) cyc();

        check("rst_status", 32'(processor_status), 32'h7);
        check("rst_lock_n", 32'(processor_lock_n), 32'h1);
        check("rst_addr", 32'(cpu_address), 32'h0);
        check("rst_data", 32'(cpu_data_bus), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_error", 32'(rsp_error), 32'h0);
        check("rst_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        reset_n = 1'b1;
        cyc();

        // memory read, zero wait states
        drive_req(3'b101, 20'hF0000, 8'h00, 1'b0);
        processor_ready = 1'b1;
        data_bus_in     = 8'hEA;
        cyc();
        req_valid = 1'b0;
        check("mr_t1_status", 32'(processor_status), 32'h5);
        check("mr_t1_addr", 32'(cpu_address), 32'hF0000);
        check("mr_t1_lock_n", 32'(processor_lock_n), 32'h1);
        check("mr_t1_ready", 32'(req_ready), 32'h0);
        cyc();
        check("mr_t2_status", 32'(processor_status), 32'h5);
        check("mr_t2_data", 32'(cpu_data_bus), 32'h0);
        cyc();
        check("mr_t3_status", 32'(processor_status), 32'h5);
        check("mr_t3_rsp_valid", 32'(rsp_valid), 32'h0);
        cyc();
        data_bus_in = 8'h11;
        check("mr_t4_status", 32'(processor_status), 32'h7);
        check("mr_t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("mr_t4_rdata", 32'(rsp_rdata), 32'hEA);
        check("mr_t4_error", 32'(rsp_error), 32'h0);
        check("mr_t4_addr", 32'(cpu_address), 32'hF0000);
        cyc();
        check("mr_idle_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mr_idle_rdata", 32'(rsp_rdata), 32'hEA);
        check("mr_idle_addr_hold", 32'(cpu_address), 32'hF0000);

        // IO write with 3 wait states
        drive_req(3'b010, 20'h00061, 8'h4C, 1'b0);
        processor_ready = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            req_valid = 1'b0;
            check($sformatf("iow_c%0d_rsp_valid", c), 32'(rsp_valid), 32'h0);
            check($sformatf("iow_c%0d_status", c), 32'(processor_status), 32'h2);
            check($sformatf("iow_c%0d_data", c), 32'(cpu_data_bus), (c >= 2) ? 32'h4C : 32'h0);
            if (c == 6) processor_ready = 1'b1;
        end
        cyc();
        check("iow_t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("iow_t4_error", 32'(rsp_error), 32'h0);
        check("iow_t4_data", 32'(cpu_data_bus), 32'h4C);
        check("iow_t4_status", 32'(processor_status), 32'h7);
        check("iow_t4_rdata_hold", 32'(rsp_rdata), 32'hEA);
        check("iow_t4_addr", 32'(cpu_address), 32'h00061);
        cyc();
        check("iow_idle_data", 32'(cpu_data_bus), 32'h0);

        // timeout: T3 + 4 TW with ready low
        drive_req(3'b101, 20'h12345, 8'h00, 1'b0);
        processor_ready = 1'b0;
        data_bus_in     = 8'h77;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            req_valid = 1'b0;
            check($sformatf("to_c%0d_rsp_valid", c), 32'(rsp_valid), 32'h0);
            check($sformatf("to_c%0d_status", c), 32'(processor_status), 32'h5);
        end
        cyc();
        check("to_t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("to_t4_error", 32'(rsp_error), 32'h1);
        check("to_t4_rdata_hold", 32'(rsp_rdata), 32'hEA);
        check("to_t4_status", 32'(processor_status), 32'h7);
        cyc();

        // ready in the final TW beats the timeout
        drive_req(3'b101, 20'h54321, 8'h00, 1'b0);
        processor_ready = 1'b0;
        data_bus_in     = 8'h5A;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            req_valid = 1'b0;
            if (c == 7) processor_ready = 1'b1;
        end
        check("lastw_tw4_status", 32'(processor_status), 32'h5);
        cyc();
        check("lastw_t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("lastw_t4_error", 32'(rsp_error), 32'h0);
        check("lastw_t4_rdata", 32'(rsp_rdata), 32'h5A);
        cyc();

        // back-to-back: read, then locked code fetch
        drive_req(3'b101, 20'h01000, 8'h00, 1'b0);
        processor_ready = 1'b1;
        data_bus_in     = 8'h31;
        cyc();
        check("b2b_c1_lock_n", 32'(processor_lock_n), 32'h1);
        drive_req(3'b100, 20'hABCDE, 8'h00, 1'b1);
        cyc();
        cyc();
        cyc();
        check("b2b_c4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("b2b_c4_rdata", 32'(rsp_rdata), 32'h31);
        check("b2b_c4_req_ready", 32'(req_ready), 32'h1);
        check("b2b_c4_lock_n", 32'(processor_lock_n), 32'h1);
        data_bus_in = 8'h42;
        cyc();
        req_valid = 1'b0;
        check("b2b_c5_status", 32'(processor_status), 32'h4);
        check("b2b_c5_addr", 32'(cpu_address), 32'hABCDE);
        check("b2b_c5_lock_n", 32'(processor_lock_n), 32'h0);
        check("b2b_c5_rsp_valid", 32'(rsp_valid), 32'h0);
        cyc();
        check("b2b_c6_lock_n", 32'(processor_lock_n), 32'h0);
        cyc();
        check("b2b_c7_lock_n", 32'(processor_lock_n), 32'h0);
        cyc();
        check("b2b_c8_rsp_valid", 32'(rsp_valid), 32'h1);
        check("b2b_c8_rdata", 32'(rsp_rdata), 32'h42);
        check("b2b_c8_lock_n", 32'(processor_lock_n), 32'h0);
        cyc();
        check("b2b_c9_lock_n", 32'(processor_lock_n), 32'h1);
        check("b2b_c9_rsp_valid", 32'(rsp_valid), 32'h0);

        // invalid type
        drive_req(3'b111, 20'hFFFFF, 8'h99, 1'b1);
        data_bus_in = 8'hC3;
        cyc();
        req_valid = 1'b0;
        check("inv_c1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("inv_c1_error", 32'(rsp_error), 32'h1);
        check("inv_c1_status", 32'(processor_status), 32'h7);
        check("inv_c1_req_ready", 32'(req_ready), 32'h0);
        check("inv_c1_rdata", 32'(rsp_rdata), 32'h42);
        check("inv_c1_lock_n", 32'(processor_lock_n), 32'h1);
        cyc();
        check("inv_c2_rsp_valid", 32'(rsp_valid), 32'h0);
        check("inv_c2_status", 32'(processor_status), 32'h7);

        // halt ignores ready
        drive_req(3'b011, 20'h00000, 8'h00, 1'b0);
        processor_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            req_valid = 1'b0;
            check($sformatf("halt_c%0d_status", c), 32'(processor_status), 32'h3);
        end
        cyc();
        check("halt_t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("halt_t4_error", 32'(rsp_error), 32'h0);
        check("halt_t4_rdata", 32'(rsp_rdata), 32'h42);
        cyc();

        // reset during TW
        drive_req(3'b101, 20'h0BEEF, 8'h00, 1'b1);
        processor_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            req_valid = 1'b0;
        end
        check("rst_tw_status", 32'(processor_status), 32'h5);
        check("rst_tw_lock_n", 32'(processor_lock_n), 32'h0);
        reset_n = 1'b0;
        cyc();
        check("rst_mid_status", 32'(processor_status), 32'h7);
        check("rst_mid_lock_n", 32'(processor_lock_n), 32'h1);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_req_ready", 32'(req_ready), 32'h1);
        check("rst_mid_addr", 32'(cpu_address), 32'h0);
        reset_n         = 1'b1;
        processor_ready = 1'b1;
        cyc();
        check("rst_after_rsp_valid", 32'(rsp_valid), 32'h0);

        drive_req(3'b001, 20'h003F8, 8'h00, 1'b0);
        data_bus_in = 8'h9C;
        cyc();
        req_valid = 1'b0;
        check("post_c1_status", 32'(processor_status), 32'h1);
        cyc();
        cyc();
        check("post_c3_rsp_valid", 32'(rsp_valid), 32'h0);
        cyc();
        check("post_t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("post_t4_rdata", 32'(rsp_rdata), 32'h9C);
        check("post_t4_error", 32'(rsp_error), 32'h0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
